// File: rtl/game_session_ctrl.sv
// game_session_ctrl: score/lives session sequencer (IDLE/PLAY/PAUSE/OVER); define GAME_SESSION_SCORE_SAT_EN for a saturating score
module game_session_ctrl #(
  parameter int clk_mhz      = 50,
  parameter int w_score      = 3,
  parameter int w_lifes      = 3,
  parameter int lifes_init   = 3,
  parameter int win_score    = 4,
  parameter int pause_frames = 60,
  parameter int w_pause      = $clog2(pause_frames + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               point,
  input  logic               life_lost,
  output logic               game_run,
  output logic               launch,
  output logic [w_score-1:0] score,
  output logic [w_lifes-1:0] n_lifes,
  output logic [1:0]         state,
  output logic               won
);
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;
  if (clk_mhz < 1 || pause_frames < 1 || lifes_init < 1 || lifes_init >= 2**w_lifes) begin : g_bad
    $error("game_session_ctrl: illegal parameters");
  end
  state_t             st;
  logic               start_q;
  logic [w_pause-1:0] cnt;
  logic [w_score-1:0] score_nx;
  logic               start_rise;
  logic               win;
  assign state      = st;
  assign start_rise = start & ~start_q;
`ifdef GAME_SESSION_SCORE_SAT_EN
  assign score_nx = &score ? score : score + 1'b1;
`else
  assign score_nx = score + 1'b1;
`endif
  assign win = win_score != 0 && 32'(score_nx) == win_score;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st       <= IDLE;
      start_q  <= 1'b1;
      cnt      <= '0;
      game_run <= 1'b0;
      launch   <= 1'b0;
      score    <= '0;
      n_lifes  <= w_lifes'(lifes_init);
      won      <= 1'b0;
    end else begin
      start_q <= start;
      launch  <= 1'b0;
      case (st)
        IDLE, OVER:
          if (start_rise) begin
            score    <= '0;
            n_lifes  <= w_lifes'(lifes_init);
            won      <= 1'b0;
            st       <= PLAY;
            game_run <= 1'b1;
            launch   <= 1'b1;
          end
        PLAY: begin
          if (point) score <= score_nx;
          if (life_lost) n_lifes <= n_lifes - 1'b1;
          // a win outranks both running out of lives and pausing
          if (point && win) begin
            won      <= 1'b1;
            st       <= OVER;
            game_run <= 1'b0;
          end else if (life_lost) begin
            game_run <= 1'b0;
            cnt      <= w_pause'(pause_frames);
            st       <= n_lifes == 1 ? OVER : PAUSE;
          end
        end
        PAUSE:
          if (frame_tick) begin
            cnt <= cnt - 1'b1;
            if (cnt == 1) begin
              st       <= PLAY;
              game_run <= 1'b1;
              launch   <= 1'b1;
            end
          end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_game_session_ctrl.sv
// tb_game_session_ctrl: scoreboard bench, directed vectors; u1 runs with win_score=0
module tb_game_session_ctrl;
  logic clk = 0, rst = 1, start = 1, frame_tick = 0, point = 0, life_lost = 0;
  logic s1 = 0, p1 = 0;
  logic run0, lau0, won0, run1, lau1, won1;
  logic [2:0] sc0, nl0, sc1, nl1;
  logic [1:0] st0, st1;
  int cyc = 0, n_chk = 0, n_fail = 0;
`ifdef GAME_SESSION_SCORE_SAT_EN
  localparam logic [2:0] SC8 = 3'd7;
`else
  localparam logic [2:0] SC8 = 3'd0;
`endif
  typedef struct { int due; bit sel; string nm; logic [10:0] v; } exp_t;
  exp_t q[$];
  exp_t e;
  logic [10:0] act;

  game_session_ctrl u0 (.clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick), .point(point),
    .life_lost(life_lost), .game_run(run0), .launch(lau0), .score(sc0), .n_lifes(nl0), .state(st0), .won(won0));
  game_session_ctrl #(.win_score(0)) u1 (.clk(clk), .rst(rst), .start(s1), .frame_tick(frame_tick), .point(p1),
    .life_lost(1'b0), .game_run(run1), .launch(lau1), .score(sc1), .n_lifes(nl1), .state(st1), .won(won1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      act = e.sel ? {st1, run1, lau1, sc1, nl1, won1} : {st0, run0, lau0, sc0, nl0, won0};
      n_chk++;
      if (e.due != cyc || act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got st/run/launch/score/lifes/won=%b required %b (due %0d, checked %0d)",
                 e.nm, act, e.v, e.due, cyc);
      end
    end

  task automatic exp(bit sel, string nm, logic [1:0] s, bit r, bit l, logic [2:0] sc, logic [2:0] nl, bit w,
                     bit now = 0);
    q.push_back('{due: cyc + (now ? 0 : 1), sel: sel, nm: nm, v: {s, r, l, sc, nl, w}});
  endtask

  task automatic step(bit s, bit t, bit p, bit l);
    @(posedge clk); #1;
    start = s; frame_tick = t; point = p; life_lost = l;
  endtask

  task automatic step1(bit s, bit p);
    @(posedge clk); #1;
    s1 = s; p1 = p;
  endtask

  initial begin
    @(posedge clk); #1;
    exp(0, "reset", 0, 0, 0, 0, 3, 0, 1);
    exp(1, "reset_u1", 0, 0, 0, 0, 3, 0, 1);
    rst = 0;
    repeat (10) begin step(1, 0, 0, 0); exp(0, "held_start", 0, 0, 0, 0, 3, 0); end
    step(0, 0, 0, 0); exp(0, "release", 0, 0, 0, 0, 3, 0);
    step(1, 0, 0, 0); exp(0, "launch", 1, 1, 1, 0, 3, 0);
    step(1, 0, 0, 0); exp(0, "launch_end", 1, 1, 0, 0, 3, 0);
    for (int k = 1; k < 4; k++) begin step(1, 0, 1, 0); exp(0, "point", 1, 1, 0, 3'(k), 3, 0); end
    step(1, 0, 1, 0); exp(0, "win", 3, 0, 0, 4, 3, 1);
    step(1, 0, 1, 1); exp(0, "over_ignore", 3, 0, 0, 4, 3, 1);
    step(0, 0, 0, 0); exp(0, "over_hold", 3, 0, 0, 4, 3, 1);
    step(1, 0, 0, 0); exp(0, "restart", 1, 1, 1, 0, 3, 0);
    step(1, 1, 0, 1); exp(0, "hit", 2, 0, 0, 0, 2, 0);
    step(1, 0, 1, 0); exp(0, "pause_point", 2, 0, 0, 0, 2, 0);
    step(0, 0, 0, 1); exp(0, "pause_lost", 2, 0, 0, 0, 2, 0);
    step(1, 0, 0, 0); exp(0, "pause_start", 2, 0, 0, 0, 2, 0);
    repeat (59) begin step(1, 1, 0, 0); exp(0, "pause_tick", 2, 0, 0, 0, 2, 0); end
    step(1, 1, 0, 0); exp(0, "resume", 1, 1, 1, 0, 2, 0);
    step(1, 0, 0, 0); exp(0, "resume_end", 1, 1, 0, 0, 2, 0);
    step(1, 0, 0, 1); exp(0, "hit2", 2, 0, 0, 0, 1, 0);
    repeat (59) step(1, 1, 0, 0);
    step(1, 1, 0, 0); exp(0, "resume2", 1, 1, 1, 0, 1, 0);
    step(1, 0, 0, 1); exp(0, "dead", 3, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0); exp(0, "dead_hold", 3, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0); exp(0, "restart2", 1, 1, 1, 0, 3, 0);
    for (int k = 1; k < 4; k++) begin step(1, 0, 1, 0); exp(0, "point2", 1, 1, 0, 3'(k), 3, 0); end
    step(1, 0, 1, 1); exp(0, "both_win", 3, 0, 0, 4, 2, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0); exp(0, "restart3", 1, 1, 1, 0, 3, 0);
    step(1, 0, 1, 0); exp(0, "point3", 1, 1, 0, 1, 3, 0);
    step(1, 0, 1, 1); exp(0, "both_pause", 2, 0, 0, 2, 2, 0);
    repeat (5) step(1, 1, 0, 0);
    @(posedge clk); #1;
    rst = 1; frame_tick = 0; point = 0; life_lost = 0;
    exp(0, "mid_pause_reset", 0, 0, 0, 0, 3, 0, 1);
    exp(1, "mid_pause_reset_u1", 0, 0, 0, 0, 3, 0, 1);
    @(posedge clk); #1;
    rst = 0;
    step1(1, 0); exp(1, "u1_launch", 1, 1, 1, 0, 3, 0);
    for (int k = 1; k < 9; k++) begin
      step1(1, 1); exp(1, "u1_point", 1, 1, 0, k < 8 ? 3'(k) : SC8, 3, 0);
    end
    step1(1, 0);
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
